// File: rtl/hdmi_mode_ctrl.sv
// Video-mode change sequencer for the HDMI timing generator: blanks output, waits for a
// frame boundary, pulses the timing reset around the mode switch, then waits for timing to settle.
// Optional VSync watchdog enabled by defining HDMI_MODE_WDOG_EN.
module hdmi_mode_ctrl #(
  parameter logic DEFAULT_MODE  = 1'b0,
  parameter int   RST_CYCLES    = 16,
  parameter int   SETTLE_FRAMES = 2,
  parameter int   WDOG_CYCLES   = 3_000_000
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       Req_Valid,
  input  logic       Req_Mode,
  output logic       Req_Ready,
  input  logic       Timing_VSync,
  output logic       Video_Mode,
  output logic       Timing_Rst_n,
  output logic       Output_En,
  output logic       Done,
  output logic       Timeout,
  output logic [1:0] dbg_state_o
);

  localparam int HW = $clog2(RST_CYCLES) + 1;
  localparam int FW = $clog2(SETTLE_FRAMES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(SETTLE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_HOLD    = 2'd2,
    ST_SETTLE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic            pend_q, pend_d;
  logic            req_q, req_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [FW-1:0]   frm_q, frm_d;
  logic            vs_q;
  logic            rst_n_q, rst_n_d;
  logic            en_q, en_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            vs_rise;
  logic            accept;
  logic            wdog_exp;

  // Handshake: a request transfers on any clk edge where Req_Valid && Req_Ready; Req_Ready
  // is high only in IDLE, and Req_Valid seen at any other time is dropped, not queued.
  assign vs_rise = Timing_VSync & ~vs_q;
  assign accept  = (state_q == ST_IDLE) & Req_Valid & ready_q;

`ifdef HDMI_MODE_WDOG_EN
  localparam logic [23:0] WDOG_LAST = 24'(WDOG_CYCLES - 1);
  logic [23:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;

  assign wdog_exp = (wdog_q == WDOG_LAST) &&
                    ((state_q == ST_WAIT_VS) || (state_q == ST_SETTLE));

  always_comb begin
    wdog_d    = '0;
    timeout_d = timeout_q;
    if (((state_q == ST_WAIT_VS) || (state_q == ST_SETTLE)) &&
        (state_d == state_q) && !vs_rise)
      wdog_d = wdog_q + 24'd1;
    if (accept)
      timeout_d = 1'b0;
    else if (wdog_exp)
      timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign Timeout = timeout_q;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
  assign wdog_exp    = 1'b0;
  assign Timeout     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    req_d   = req_q;
    hold_d  = hold_q;
    frm_d   = frm_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (Req_Mode == mode_q) begin
            done_d = 1'b1;
          end else begin
            pend_d  = Req_Mode;
            req_d   = 1'b1;
            state_d = ST_WAIT_VS;
          end
        end
      end
      ST_WAIT_VS: begin
        if (vs_rise || wdog_exp) begin
          state_d = ST_HOLD;
          mode_d  = pend_q;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_SETTLE;
          frm_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if ((vs_rise && (frm_q == FRM_LAST)) || wdog_exp) begin
          state_d = ST_IDLE;
          done_d  = req_q;
          req_d   = 1'b0;
        end else if (vs_rise) begin
          frm_d = frm_q + 1'b1;
        end
      end
      default: state_d = ST_HOLD;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    rst_n_d = (state_d != ST_HOLD);
    en_d    = (state_d == ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_HOLD;
      mode_q  <= DEFAULT_MODE;
      pend_q  <= DEFAULT_MODE;
      req_q   <= 1'b0;
      hold_q  <= '0;
      frm_q   <= '0;
      vs_q    <= 1'b0;
      rst_n_q <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
      frm_q   <= frm_d;
      vs_q    <= Timing_VSync;
      rst_n_q <= rst_n_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign Video_Mode   = mode_q;
  assign Timing_Rst_n = rst_n_q;
  assign Output_En    = en_q;
  assign Req_Ready    = ready_q;
  assign Done         = done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_hdmi_mode_ctrl.sv
// Directed bench for hdmi_mode_ctrl: power-up, mode switch, same-mode request, ignored request,
// reset mid-switch, and (with HDMI_MODE_WDOG_EN) the VSync watchdog.
module tb_hdmi_mode_ctrl;

  logic       clk;
  logic       Rst;
  logic       Req_Valid;
  logic       Req_Mode;
  logic       Req_Ready;
  logic       Timing_VSync;
  logic       Video_Mode;
  logic       Timing_Rst_n;
  logic       Output_En;
  logic       Done;
  logic       Timeout;
  logic [1:0] dbg_state;

  int n_vec    = 0;
  int n_miss   = 0;
  int vs_rises = 0;
  int done_cnt = 0;
  logic vs_stuck = 1'b0;

  hdmi_mode_ctrl #(
    .DEFAULT_MODE (1'b0),
    .RST_CYCLES   (4),
    .SETTLE_FRAMES(2),
    .WDOG_CYCLES  (1000)
  ) dut (
    .clk         (clk),
    .Rst         (Rst),
    .Req_Valid   (Req_Valid),
    .Req_Mode    (Req_Mode),
    .Req_Ready   (Req_Ready),
    .Timing_VSync(Timing_VSync),
    .Video_Mode  (Video_Mode),
    .Timing_Rst_n(Timing_Rst_n),
    .Output_En   (Output_En),
    .Done        (Done),
    .Timeout     (Timeout),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VSync model: 4-cycle pulse every 200 clk, driven on the falling edge
  initial begin
    int   phase;
    logic nv;
    phase        = 0;
    Timing_VSync = 1'b0;
    forever begin
      @(negedge clk);
      phase = (phase == 199) ? 0 : phase + 1;
      nv    = !vs_stuck && (phase < 4);
      if (nv && !Timing_VSync) vs_rises++;
      Timing_VSync = nv;
    end
  end

  always @(negedge clk) if (Done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel 0 = Timing_Rst_n, 1 = Output_En; n = clk edges until the signal reaches lvl
  task automatic wait_for(input string tag, input int sel, input logic lvl, input int limit,
                          output int n);
    logic v;
    n = 0;
    do begin
      tick();
      n++;
      v = (sel == 0) ? Timing_Rst_n : Output_En;
    end while (v !== lvl && n < limit);
    chk({tag, "_reached"}, 32'(v), 32'(lvl));
  endtask

  task automatic req(input logic m);
    @(negedge clk);
    Req_Valid = 1'b1;
    Req_Mode  = m;
    tick();
    Req_Valid = 1'b0;
  endtask

  task automatic power_up(input string tag);
    int n, r0, d0;
    d0 = done_cnt;
    wait_for({tag, "_hold"}, 0, 1'b1, 50, n);
    chk({tag, "_hold_len"}, n, 4);
    r0 = vs_rises;
    wait_for({tag, "_settle"}, 1, 1'b1, 1000, n);
    chk({tag, "_settle_rises"}, vs_rises - r0, 2);
    chk({tag, "_mode"}, 32'(Video_Mode), 0);
    chk({tag, "_ready"}, 32'(Req_Ready), 1);
    chk({tag, "_state"}, 32'(dbg_state), 0);
    tick();
    chk({tag, "_no_done"}, done_cnt - d0, 0);
  endtask

  initial begin
    int n, r0, d0;
    logic drop;
    Rst       = 1'b0;
    Req_Valid = 1'b0;
    Req_Mode  = 1'b0;

    // 1. reset values and power-up bring-up
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mode", 32'(Video_Mode), 0);
    chk("rst_tim_rst_n", 32'(Timing_Rst_n), 0);
    chk("rst_out_en", 32'(Output_En), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_ready", 32'(Req_Ready), 0);
    chk("rst_timeout", 32'(Timeout), 0);
    chk("rst_state", 32'(dbg_state), 2);
    @(negedge clk);
    Rst = 1'b1;
    power_up("pu1");

    // 3. same-mode request completes at once without disturbing timing
    d0 = done_cnt;
    req(1'b0);
    chk("same_done", 32'(Done), 1);
    chk("same_out_en", 32'(Output_En), 1);
    chk("same_ready", 32'(Req_Ready), 1);
    drop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Output_En !== 1'b1 || Timing_Rst_n !== 1'b1) drop = 1'b1;
    end
    chk("same_no_drop", 32'(drop), 0);
    chk("same_done_cnt", done_cnt - d0, 1);

    // 2. switch to mode 1
    d0 = done_cnt;
    req(1'b1);
    r0 = vs_rises;
    chk("sw1_out_en_low", 32'(Output_En), 0);
    chk("sw1_ready_low", 32'(Req_Ready), 0);
    chk("sw1_mode_old", 32'(Video_Mode), 0);
    chk("sw1_state_wait", 32'(dbg_state), 1);
    wait_for("sw1_hold_in", 0, 1'b0, 400, n);
    chk("sw1_hold_on_rise", vs_rises - r0, 1);
    chk("sw1_mode_new", 32'(Video_Mode), 1);
    wait_for("sw1_hold_out", 0, 1'b1, 50, n);
    chk("sw1_hold_len", n, 4);
    r0 = vs_rises;
    wait_for("sw1_settle", 1, 1'b1, 1000, n);
    chk("sw1_settle_rises", vs_rises - r0, 2);
    chk("sw1_done", 32'(Done), 1);
    tick();
    chk("sw1_done_cnt", done_cnt - d0, 1);
    chk("sw1_mode_final", 32'(Video_Mode), 1);

    // 4. switch back to 0, with a stray request pulsed during SETTLE
    d0 = done_cnt;
    req(1'b0);
    wait_for("sw0_hold_in", 0, 1'b0, 400, n);
    wait_for("sw0_hold_out", 0, 1'b1, 50, n);
    req(1'b1);
    chk("sw0_stray_ready", 32'(Req_Ready), 0);
    wait_for("sw0_settle", 1, 1'b1, 1000, n);
    repeat (8) tick();
    chk("sw0_mode", 32'(Video_Mode), 0);
    chk("sw0_state", 32'(dbg_state), 0);
    chk("sw0_done_cnt", done_cnt - d0, 1);

    // 5. reset asserted during HOLD of a switch
    req(1'b1);
    wait_for("rs_hold_in", 0, 1'b0, 400, n);
    chk("rs_mode_pre", 32'(Video_Mode), 1);
    @(negedge clk);
    Rst = 1'b0;
    #1;
    chk("rs_mode", 32'(Video_Mode), 0);
    chk("rs_tim_rst_n", 32'(Timing_Rst_n), 0);
    chk("rs_out_en", 32'(Output_En), 0);
    chk("rs_ready", 32'(Req_Ready), 0);
    chk("rs_state", 32'(dbg_state), 2);
    repeat (2) @(negedge clk);
    Rst = 1'b1;
    power_up("pu2");

`ifdef HDMI_MODE_WDOG_EN
    // 6. VSync stuck low: both waits end on the watchdog
    vs_stuck = 1'b1;
    repeat (4) tick();
    req(1'b1);
    wait_for("wd_wait", 0, 1'b0, 2000, n);
    chk("wd_wait_len", n, 1000);
    chk("wd_timeout", 32'(Timeout), 1);
    chk("wd_mode", 32'(Video_Mode), 1);
    wait_for("wd_hold", 0, 1'b1, 50, n);
    chk("wd_hold_len", n, 4);
    wait_for("wd_settle", 1, 1'b1, 2000, n);
    chk("wd_settle_len", n, 1000);
    vs_stuck = 1'b0;
    req(1'b0);
    chk("wd_timeout_clr", 32'(Timeout), 0);
    wait_for("wd_final", 1, 1'b1, 1000, n);
    chk("wd_final_mode", 32'(Video_Mode), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

endmodule
